// File: rtl/stream_sequencer.sv
// stream_sequencer
// Frames one image through an external pixel pipeline that only advances when
// pipe_en is high. Pixels are taken from an input stream during RUN. FLUSH then
// pushes zeros until the last real pixel has left the pipeline. The pipeline
// result is presented as an output stream, and the sequencer stalls whenever
// the downstream consumer is not ready to take a pipeline result.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   start                      one-cycle request to process a frame (IDLE only)
//   in_valid/in_ready/in_data  input pixel stream, {B,G,R}
//   pipe_en                    pipeline advance strobe
//   pipe_hsync/pipe_vsync      row/frame start markers, qualified by pipe_en
//   pipe_data                  pixel pushed into the pipeline
//   pipe_out                   pipeline result (combinational from its registers)
//   out_valid/out_ready        output pixel stream handshake
//   out_data/out_last          output pixel and end-of-frame marker
//   busy                       high while a frame is in RUN or FLUSH
//   frame_done                 one-cycle pulse when a frame completes
module stream_sequencer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int LATENCY      = 643
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    output logic        pipe_en,
    output logic        pipe_hsync,
    output logic        pipe_vsync,
    output logic [23:0] pipe_data,
    input  logic [23:0] pipe_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        frame_done
);

    localparam int N     = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int TOTAL = N + LATENCY;
    // fed must reach TOTAL without wrapping.
    localparam int FED_W = $clog2(TOTAL + 1);
    localparam int X_W   = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int Y_W   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    localparam logic [FED_W-1:0] LAT_C     = FED_W'(LATENCY);
    localparam logic [FED_W-1:0] RUN_END   = FED_W'(N - 1);
    localparam logic [FED_W-1:0] FLUSH_END = FED_W'(TOTAL - 1);
    localparam logic [X_W-1:0]   X_MAX     = X_W'(FRAME_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [FED_W-1:0] fed;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             primed;
    logic             ok;

    // Once the pipeline holds LATENCY advances, every further advance pops a
    // real result, so the pipeline may only move when downstream can take it.
    assign primed = (fed >= LAT_C);
    assign ok     = out_ready | ~primed;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state handshake decoding. in_ready depends only on
    // state, fed and out_ready, never on in_valid.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        pipe_en    = 1'b0;
        pipe_data  = '0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready  = ok;
                pipe_en   = in_valid & ok;
                pipe_data = in_data;
                if (pipe_en && (fed == RUN_END)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Always primed here, so the pipeline moves only with out_ready.
                pipe_en = out_ready;
                if (pipe_en && (fed == FLUSH_END)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Advance counter and raster coordinates. They restart on every accepted
    // start and keep running through FLUSH so sync markers stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fed <= '0;
            x   <= '0;
            y   <= '0;
        end else if ((state == IDLE) && start) begin
            fed <= '0;
            x   <= '0;
            y   <= '0;
        end else if (pipe_en) begin
            fed <= fed + FED_W'(1);
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

    assign out_valid  = pipe_en & primed;
    assign out_last   = out_valid & (fed == FLUSH_END);
    assign out_data   = pipe_out;
    assign pipe_hsync = pipe_en & (x == '0);
    assign pipe_vsync = pipe_en & (x == '0) & (y == '0);
    assign busy       = (state == RUN) || (state == FLUSH);

endmodule
